// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and data widths.
package loader_pkg;

    localparam int BYTE_WIDTH  = 8;
    localparam int INSTR_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_COUNT = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_CHK   = 3'd3,
        ST_FIN   = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-source / CPU-load-port bundle for the program loader.
// slave: the loader itself; master: the byte source and CPU side.
interface program_loader_if #(parameter int ADDR_WIDTH = 8);
    import loader_pkg::*;

    logic [BYTE_WIDTH-1:0]  i_byte;
    logic                   i_byte_valid;
    logic                   i_loopf;
    logic [ADDR_WIDTH-1:0]  o_instr_addr;
    logic [INSTR_WIDTH-1:0] o_instr;
    logic                   o_we;
    logic                   o_ON;
    logic                   o_cpu_rst;
    logic                   o_busy;
    logic                   o_err;
    logic                   o_halted;

    modport slave (
        input  i_byte, i_byte_valid, i_loopf,
        output o_instr_addr, o_instr, o_we, o_ON, o_cpu_rst, o_busy, o_err, o_halted
    );

    modport master (
        output i_byte, i_byte_valid, i_loopf,
        input  o_instr_addr, o_instr, o_we, o_ON, o_cpu_rst, o_busy, o_err, o_halted
    );

endinterface

// File: rtl/program_loader_byte_timer.sv
// Idle counter between received bytes. o_expired flags the cycle that would
// complete LIMIT consecutive idle cycles, so the owner can leave on that edge.
module byte_timer #(
    parameter int LIMIT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    // Count idle cycles while enabled; any byte or leaving the window restarts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt_q <= '0;
        else if (i_clr || !i_en)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CW'(1);
    end

    assign o_expired = i_en && !i_clr && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/program_loader.sv
// Byte-serial program loader: count byte, N big-endian instructions, optional
// checksum byte; writes the CPU instruction memory then releases the CPU.
// Optional checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    program_loader_if.slave  bus
);

    // Must hold both any count byte and the 2^ADDR_WIDTH meaning of 0.
    localparam int REM_W = (ADDR_WIDTH + 1 > BYTE_WIDTH) ? ADDR_WIDTH + 1 : BYTE_WIDTH;

    state_t                 state_q, state_d;
    logic                   strobe, load_cnt, wr_lo, last_instr, tmo_exp;
    logic [BYTE_WIDTH-1:0]  hi_q;
    logic [ADDR_WIDTH-1:0]  addr_q, waddr_q;
    logic [REM_W-1:0]       rem_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   we_q, on_q, halted_q;

    assign strobe     = bus.i_byte_valid;
    // A strobe in COUNT, RUN or ERR is always a fresh count byte.
    assign load_cnt   = strobe && (state_q == ST_COUNT || state_q == ST_RUN || state_q == ST_ERR);
    assign wr_lo      = strobe && (state_q == ST_LO);
    assign last_instr = (rem_q <= REM_W'(1));

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] sum_q;

    // Running mod-256 sum of instruction bytes only; the count byte restarts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            sum_q <= '0;
        else if (load_cnt)
            sum_q <= '0;
        else if (strobe && (state_q == ST_HI || state_q == ST_LO))
            sum_q <= sum_q + bus.i_byte;
    end
`endif

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            logic active;
            assign active = (state_q == ST_HI) || (state_q == ST_LO) || (state_q == ST_CHK);
            byte_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_clr     (strobe),
                .i_en      (active),
                .o_expired (tmo_exp)
            );
        end else begin : g_no_tmo
            assign tmo_exp = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= ST_COUNT;
        else
            state_q <= state_d;
    end

    // Next-state logic: bytes advance the frame, idle timeout aborts it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COUNT, ST_RUN, ST_ERR: if (strobe) state_d = ST_HI;
            ST_HI: begin
                if (strobe)       state_d = ST_LO;
                else if (tmo_exp) state_d = ST_ERR;
            end
            ST_LO: begin
                if (strobe) begin
                    if (!last_instr)
                        state_d = ST_HI;
                    else
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_FIN;
`endif
                end else if (tmo_exp) begin
                    state_d = ST_ERR;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (strobe)       state_d = (bus.i_byte == sum_q) ? ST_FIN : ST_ERR;
                else if (tmo_exp) state_d = ST_ERR;
            end
`endif
            // Guard cycle so the last write lands while the CPU is still in load mode.
            ST_FIN:  state_d = ST_RUN;
            default: state_d = ST_COUNT;
        endcase
    end

    // Datapath: instruction assembly, write port, run/halt flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hi_q     <= '0;
            addr_q   <= '0;
            waddr_q  <= '0;
            rem_q    <= '0;
            instr_q  <= '0;
            we_q     <= 1'b0;
            on_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            // ON follows RUN one cycle late, giving the 2-cycle gap after the last write.
            on_q <= (state_q == ST_RUN) && !strobe;
            if (load_cnt) begin
                rem_q  <= (bus.i_byte == '0) ? (REM_W'(1) << ADDR_WIDTH) : REM_W'(bus.i_byte);
                addr_q <= '0;
            end
            if (strobe && state_q == ST_HI)
                hi_q <= bus.i_byte;
            if (wr_lo) begin
                instr_q <= {hi_q, bus.i_byte};
                waddr_q <= addr_q;
                we_q    <= 1'b1;
                addr_q  <= addr_q + ADDR_WIDTH'(1);
                rem_q   <= rem_q - REM_W'(1);
            end
            if (state_q == ST_RUN && strobe)
                halted_q <= 1'b0;
            else if (state_q == ST_RUN && bus.i_loopf)
                halted_q <= 1'b1;
        end
    end

    assign bus.o_instr_addr = waddr_q;
    assign bus.o_instr      = instr_q;
    assign bus.o_we         = we_q;
    assign bus.o_ON         = on_q;
    assign bus.o_cpu_rst    = (state_q != ST_RUN);
    assign bus.o_busy       = (state_q == ST_HI) || (state_q == ST_LO) ||
                              (state_q == ST_CHK) || (state_q == ST_FIN);
    assign bus.o_err        = (state_q == ST_ERR);
    assign bus.o_halted     = halted_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: drivers push expected writes into a queue, a
// negedge monitor pops and compares on every write pulse.
module tb_program_loader;

    localparam int AW  = 8;
    localparam int TMO = 10;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   instr;
    } wr_t;
    typedef logic [15:0] prog_t[$];

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    wr_t  exp_q[$];
    wr_t  want;

    always #5 clk = ~clk;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Write monitor: every pulse must match the next expected write.
    always @(negedge clk) begin
        if (!rst && bus.o_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we: got addr %0h instr %0h expected no write",
                         bus.o_instr_addr, bus.o_instr);
            end else begin
                want = exp_q.pop_front();
                check("we_data", {8'h0, bus.o_instr_addr, bus.o_instr}, {8'h0, want});
            end
            check("we_while_on", bus.o_ON, 1'b0);
        end
    end

    task automatic idle();
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = 8'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = b;
    endtask

    task automatic gap(input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) idle();
    endtask

    // Instruction bytes (and checksum), then the ON release timing.
    task automatic finish_frame(input prog_t prog, input int maxgap);
        logic [7:0] sum;
        sum = 8'h0;
        for (int i = 0; i < prog.size(); i++) begin
            gap(maxgap);
            send_byte(prog[i][15:8]);
            gap(maxgap);
            exp_q.push_back(wr_t'{addr: AW'(i), instr: prog[i]});
            send_byte(prog[i][7:0]);
            sum = 8'(sum + prog[i][15:8] + prog[i][7:0]);
        end
`ifdef LOADER_CHECKSUM_EN
        gap(maxgap);
        send_byte(sum);
`endif
        idle();
        check("on_guard1", bus.o_ON, 1'b0);
        idle();
        check("on_guard2", bus.o_ON, 1'b0);
        check("cpu_rst_run", bus.o_cpu_rst, 1'b0);
        idle();
        check("on_run", bus.o_ON, 1'b1);
        check("busy_run", bus.o_busy, 1'b0);
    endtask

    task automatic load_frame(input prog_t prog, input int maxgap);
        send_byte(8'(prog.size()));
        finish_frame(prog, maxgap);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},    bus.o_instr_addr, 0);
        check({tag, "_instr"},   bus.o_instr, 0);
        check({tag, "_we"},      bus.o_we, 0);
        check({tag, "_on"},      bus.o_ON, 0);
        check({tag, "_cpu_rst"}, bus.o_cpu_rst, 1);
        check({tag, "_busy"},    bus.o_busy, 0);
        check({tag, "_err"},     bus.o_err, 0);
        check({tag, "_halted"},  bus.o_halted, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        prog_t p;
        int    early;
        int    n;

        rst              = 1'b1;
        bus.i_byte       = 8'h0;
        bus.i_byte_valid = 1'b0;
        bus.i_loopf      = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        idle();
        check_reset_outputs("idle");

        // loopf outside RUN must not set halted
        bus.i_loopf = 1'b1;
        idle();
        idle();
        bus.i_loopf = 1'b0;
        check("halted_not_run", bus.o_halted, 1'b0);

        // Directed frame 02,12,34,AB,CD
        p.delete(); p.push_back(16'h1234); p.push_back(16'hABCD);
        send_byte(8'd2);
        idle();
        check("busy_frame", bus.o_busy, 1'b1);
        finish_frame(p, 2);

        // Halt detection and abort by a new count byte
        @(negedge clk) bus.i_loopf = 1'b1;
        @(negedge clk) bus.i_loopf = 1'b0;
        check("halted_set", bus.o_halted, 1'b1);
        repeat (3) idle();
        check("halted_sticky", bus.o_halted, 1'b1);
        send_byte(8'd1);
        idle();
        check("abort_on", bus.o_ON, 1'b0);
        check("abort_halted", bus.o_halted, 1'b0);
        check("abort_busy", bus.o_busy, 1'b1);
        p.delete(); p.push_back(16'h5566);
        finish_frame(p, 1);

        // Back-to-back strobes: 01,00,07
        p.delete(); p.push_back(16'h0007);
        load_frame(p, 0);

        // Idle timeout inside a frame
        send_byte(8'd1);
        send_byte(8'h12);
        early = 0;
        for (int k = 1; k <= TMO; k++) begin
            idle();
            if (bus.o_err) early++;
        end
        check("tmo_early", early, 0);
        idle();
        check("tmo_err", bus.o_err, 1'b1);
        check("tmo_busy", bus.o_busy, 1'b0);
        check("tmo_on", bus.o_ON, 1'b0);
        send_byte(8'd1);
        idle();
        check("tmo_clear", bus.o_err, 1'b0);
        check("tmo_restart", bus.o_busy, 1'b1);
        p.delete(); p.push_back(16'h3456);
        finish_frame(p, 2);

`ifdef LOADER_CHECKSUM_EN
        p.delete(); p.push_back(16'h1020);
        load_frame(p, 1);
        send_byte(8'd1);
        send_byte(8'h10);
        exp_q.push_back(wr_t'{addr: AW'(0), instr: 16'h1020});
        send_byte(8'h20);
        send_byte(8'h31);
        idle();
        check("chk_err", bus.o_err, 1'b1);
        check("chk_on", bus.o_ON, 1'b0);
        repeat (3) idle();
        check("chk_on_stays", bus.o_ON, 1'b0);
        check("chk_err_stays", bus.o_err, 1'b1);
`endif

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            n = int'($urandom_range(6, 1));
            p.delete();
            for (int i = 0; i < n; i++) p.push_back(16'($urandom));
            load_frame(p, 3);
        end

        // Count byte 0 means a full 256-instruction image
        p.delete();
        for (int i = 0; i < 256; i++) p.push_back(16'($urandom));
        load_frame(p, 0);

        // Reset while waiting for a low byte
        send_byte(8'd3);
        send_byte(8'h11);
        exp_q.push_back(wr_t'{addr: AW'(0), instr: 16'h1122});
        send_byte(8'h22);
        send_byte(8'h33);
        idle();
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk) rst = 1'b0;
        check("midrst_queue", exp_q.size(), 0);
        p.delete(); p.push_back(16'hAABB);
        load_frame(p, 1);

        repeat (3) idle();
        check("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
